// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM driving datapath enables and muxes.
// Optional MAINFSM_BNE_EN adds the bne instruction (BNEEX state); otherwise bne is tied 0.
module main_ctrl_fsm #(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
  output logic       bne,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       halted
);

  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] RTYPEEX = STATE_W'(6);
  localparam logic [STATE_W-1:0] RTYPEWB = STATE_W'(7);
  localparam logic [STATE_W-1:0] BEQEX   = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] IMMWB   = STATE_W'(10);
  localparam logic [STATE_W-1:0] JEX     = STATE_W'(11);
  localparam logic [STATE_W-1:0] ORIEX   = STATE_W'(12);
  localparam logic [STATE_W-1:0] BNEEX   = STATE_W'(13);
  localparam logic [STATE_W-1:0] HALT    = STATE_W'(14);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [STATE_W-1:0] ILL_NEXT = ILLEGAL_HALT ? HALT : FETCH;

  logic [STATE_W-1:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JEX;
`ifdef MAINFSM_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      state_d = ILL_NEXT;
        endcase
      end
      // IR is stable, so op is re-sampled to split lw/sw.
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = IMMWB;
      ORIEX:   state_d = IMMWB;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    immzext  = 1'b0;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        immzext = 1'b1;
        aluop   = 2'b11;
      end
      IMMWB:   regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MAINFSM_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
      end
`endif
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

`ifdef MAINFSM_BNE_EN
  assign bne = (state_q == BNEEX);
`else
  assign bne = 1'b0;
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: two instances (illegal op -> FETCH / -> HALT)
// compared cycle by cycle against hand-written output signatures.
module tb_main_ctrl_fsm;

  // {pcwrite,branch,bne,iord,memwrite,irwrite,regdst,memtoreg,regwrite,
  //  alusrca,alusrcb[1:0],immzext,pcsrc[1:0],aluop[1:0],halted}
  localparam logic [17:0] S_FETCH  = 18'b1_0_0_0_0_1_0_0_0_0_01_0_00_00_0;
  localparam logic [17:0] S_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_11_0_00_00_0;
  localparam logic [17:0] S_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
  localparam logic [17:0] S_MEMRD  = 18'b0_0_0_1_0_0_0_0_0_0_00_0_00_00_0;
  localparam logic [17:0] S_MEMWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_0_00_00_0;
  localparam logic [17:0] S_MEMWR  = 18'b0_0_0_1_1_0_0_0_0_0_00_0_00_00_0;
  localparam logic [17:0] S_RTEX   = 18'b0_0_0_0_0_0_0_0_0_1_00_0_00_10_0;
  localparam logic [17:0] S_RTWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_0_00_00_0;
  localparam logic [17:0] S_BEQEX  = 18'b0_1_0_0_0_0_0_0_0_1_00_0_01_01_0;
  localparam logic [17:0] S_ADDIEX = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
  localparam logic [17:0] S_ORIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_1_00_11_0;
  localparam logic [17:0] S_IMMWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_0_00_00_0;
  localparam logic [17:0] S_JEX    = 18'b1_0_0_0_0_0_0_0_0_0_00_0_10_00_0;
  localparam logic [17:0] S_BNEEX  = 18'b0_0_1_0_0_0_0_0_0_1_00_0_01_01_0;
  localparam logic [17:0] S_HALT   = 18'b0_0_0_0_0_0_0_0_0_0_00_0_00_00_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  int         checks = 0;
  int         errors = 0;

  logic       a_pcw, a_br, a_bne, a_iord, a_mw, a_irw, a_rd, a_m2r, a_rw;
  logic       a_sa, a_iz, a_hlt;
  logic [1:0] a_sb, a_pcs, a_aop;
  logic       b_pcw, b_br, b_bne, b_iord, b_mw, b_irw, b_rd, b_m2r, b_rw;
  logic       b_sa, b_iz, b_hlt;
  logic [1:0] b_sb, b_pcs, b_aop;
  logic [17:0] sig_a, sig_b;

  always #5 clk = ~clk;

  main_ctrl_fsm #(.STATE_W(4), .ILLEGAL_HALT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(a_pcw), .branch(a_br), .bne(a_bne), .iord(a_iord),
    .memwrite(a_mw), .irwrite(a_irw), .regdst(a_rd), .memtoreg(a_m2r),
    .regwrite(a_rw), .alusrca(a_sa), .alusrcb(a_sb), .immzext(a_iz),
    .pcsrc(a_pcs), .aluop(a_aop), .halted(a_hlt)
  );

  main_ctrl_fsm #(.STATE_W(4), .ILLEGAL_HALT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(b_pcw), .branch(b_br), .bne(b_bne), .iord(b_iord),
    .memwrite(b_mw), .irwrite(b_irw), .regdst(b_rd), .memtoreg(b_m2r),
    .regwrite(b_rw), .alusrca(b_sa), .alusrcb(b_sb), .immzext(b_iz),
    .pcsrc(b_pcs), .aluop(b_aop), .halted(b_hlt)
  );

  assign sig_a = {a_pcw, a_br, a_bne, a_iord, a_mw, a_irw, a_rd, a_m2r,
                  a_rw, a_sa, a_sb, a_iz, a_pcs, a_aop, a_hlt};
  assign sig_b = {b_pcw, b_br, b_bne, b_iord, b_mw, b_irw, b_rd, b_m2r,
                  b_rw, b_sa, b_sb, b_iz, b_pcs, b_aop, b_hlt};

  task automatic chk(input string tag, input logic [17:0] got,
                     input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [17:0] ea,
                      input logic [17:0] eb);
    @(posedge clk);
    #1;
    chk({tag, "/a"}, sig_a, ea);
    chk({tag, "/b"}, sig_b, eb);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(tag, S_FETCH, S_FETCH);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'($urandom);
    do_reset("reset");

    op = 6'b100011;
    step("lw.dec", S_DECODE, S_DECODE);
    step("lw.adr", S_MEMADR, S_MEMADR);
    step("lw.rd", S_MEMRD, S_MEMRD);
    step("lw.wb", S_MEMWB, S_MEMWB);
    step("lw.fe", S_FETCH, S_FETCH);

    op = 6'b001101;
    step("ori.dec", S_DECODE, S_DECODE);
    step("ori.ex", S_ORIEX, S_ORIEX);
    step("ori.wb", S_IMMWB, S_IMMWB);
    step("ori.fe", S_FETCH, S_FETCH);

    op = 6'b000000;
    step("r.dec", S_DECODE, S_DECODE);
    step("r.ex", S_RTEX, S_RTEX);
    step("r.wb", S_RTWB, S_RTWB);
    step("r.fe", S_FETCH, S_FETCH);

    op = 6'b000100;
    step("beq.dec", S_DECODE, S_DECODE);
    step("beq.ex", S_BEQEX, S_BEQEX);
    step("beq.fe", S_FETCH, S_FETCH);

    op = 6'b001000;
    step("addi.dec", S_DECODE, S_DECODE);
    step("addi.ex", S_ADDIEX, S_ADDIEX);
    step("addi.wb", S_IMMWB, S_IMMWB);
    step("addi.fe", S_FETCH, S_FETCH);

    op = 6'b000010;
    step("j.dec", S_DECODE, S_DECODE);
    step("j.ex", S_JEX, S_JEX);
    step("j.fe", S_FETCH, S_FETCH);

    op = 6'b101011;
    step("sw.dec", S_DECODE, S_DECODE);
    step("sw.adr", S_MEMADR, S_MEMADR);
    step("sw.wr", S_MEMWR, S_MEMWR);
    do_reset("sw.rst");
    step("sw.dec2", S_DECODE, S_DECODE);
    do_reset("sw.rst2");

    op = 6'b111111;
    step("ill.dec", S_DECODE, S_DECODE);
    step("ill.nxt", S_FETCH, S_HALT);
    for (int i = 0; i < 10; i++)
      step("ill.hold", (i % 2 == 0) ? S_DECODE : S_FETCH, S_HALT);
    do_reset("ill.rst");
    step("ill.dec2", S_DECODE, S_DECODE);
    do_reset("ill.rst2");

    op = 6'b000101;
    step("bne.dec", S_DECODE, S_DECODE);
`ifdef MAINFSM_BNE_EN
    step("bne.ex", S_BNEEX, S_BNEEX);
    step("bne.fe", S_FETCH, S_FETCH);
    step("bne.dec2", S_DECODE, S_DECODE);
    step("bne.ex2", S_BNEEX, S_BNEEX);
    do_reset("bne.rst");
`else
    step("bne.ill", S_FETCH, S_HALT);
    step("bne.hold", S_DECODE, S_HALT);
    do_reset("bne.rst");
`endif
    step("end.dec", S_DECODE, S_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
